// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz master slice.
package quiz_pkg;

    // Round-sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        JUDGE,
        DONE
    } quiz_state_t;

    // Taps at bits 7,5,4,3 of the 8-bit Fibonacci LFSR.
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h5A;

    // One LFSR step: shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/quiz_master_if.sv
// Board-side question/answer signals between the player inputs and the quiz master.
interface quiz_master_if;
    logic       start;
    logic       submit;
    logic [7:0] guess;
    logic [7:0] target;
    logic       correct;
    logic       wrong;
    logic [6:0] round_num;
    logic       game_over;
    logic       busy;

    // Player / stimulus side.
    modport master (
        output start, submit, guess,
        input  target, correct, wrong, round_num, game_over, busy
    );

    // Quiz master side.
    modport slave (
        input  start, submit, guess,
        output target, correct, wrong, round_num, game_over, busy
    );
endinterface

// File: rtl/quiz_lfsr8.sv
// 8-bit Fibonacci LFSR used as the question generator.
module quiz_lfsr8
    import quiz_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_seed,
    input  logic       advance,
    output logic [7:0] value
);

    // Seed on reset or on request, otherwise step only when asked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= SEED;
        end else if (load_seed) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/quiz_master.sv
// Quiz round sequencer: issues targets, times the player, judges guesses.
module quiz_master
    import quiz_pkg::*;
#(
    parameter int         NUM_ROUNDS     = 10,
    parameter int         TIMEOUT_CYCLES = 250_000_000,
    parameter logic [7:0] LFSR_SEED      = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst,
    quiz_master_if.slave  qif
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]    LAST_ROUND = 7'(NUM_ROUNDS);

    quiz_state_t   state_reg;
    logic [7:0]    lfsr_value;
    logic [7:0]    target_reg;
    logic [7:0]    guess_reg;
    logic [TW-1:0] timer_reg;
    logic [6:0]    round_reg;
    logic          timed_out_reg;
    logic          correct_reg;
    logic          wrong_reg;
    logic          game_over_reg;
    logic          busy_reg;

    // The sequence is only reseeded by reset, so consecutive games continue it.
    quiz_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load_seed (1'b0),
        .advance   (state_reg == ISSUE),
        .value     (lfsr_value)
    );

    // Round FSM with registered pulses and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            target_reg    <= 8'h00;
            guess_reg     <= 8'h00;
            timer_reg     <= '0;
            round_reg     <= 7'd0;
            timed_out_reg <= 1'b0;
            correct_reg   <= 1'b0;
            wrong_reg     <= 1'b0;
            game_over_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            correct_reg <= 1'b0;
            wrong_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (qif.start) begin
                        busy_reg  <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    target_reg <= lfsr_value;
                    timer_reg  <= '0;
                    round_reg  <= round_reg + 7'd1;
                    state_reg  <= WAIT;
                end
                WAIT: begin
                    // A submit in the timeout cycle still gets judged on its merits.
                    if (qif.submit) begin
                        guess_reg     <= qif.guess;
                        timed_out_reg <= 1'b0;
                        state_reg     <= JUDGE;
                    end else if (timer_reg == TIMER_LAST) begin
                        timed_out_reg <= 1'b1;
                        state_reg     <= JUDGE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                JUDGE: begin
                    if (!timed_out_reg && (guess_reg == target_reg)) begin
                        correct_reg <= 1'b1;
                    end else begin
                        wrong_reg <= 1'b1;
                    end
                    if (round_reg == LAST_ROUND) begin
                        game_over_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= DONE;
                    end else begin
                        state_reg <= ISSUE;
                    end
                end
                DONE: begin
                    if (qif.start) begin
                        round_reg     <= 7'd0;
                        game_over_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign qif.target    = target_reg;
    assign qif.correct   = correct_reg;
    assign qif.wrong     = wrong_reg;
    assign qif.round_num = round_reg;
    assign qif.game_over = game_over_reg;
    assign qif.busy      = busy_reg;

endmodule

// File: tb/tb_quiz_master.sv
// Directed bench for quiz_master (NUM_ROUNDS=3, TIMEOUT_CYCLES=16).
module tb_quiz_master;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    quiz_master_if qif ();

    quiz_master #(
        .NUM_ROUNDS     (3),
        .TIMEOUT_CYCLES (16),
        .LFSR_SEED      (8'h5A)
    ) dut (
        .clk (clk),
        .rst (rst),
        .qif (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one clock; leave the bench 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        qif.start  = 1'b0;
        qif.submit = 1'b0;
        qif.guess  = 8'h00;
        ticks(2);

        // Reset state
        check("rst_target", qif.target, 8'h00);
        check("rst_round", qif.round_num, 7'd0);
        check("rst_busy", qif.busy, 1'b0);
        check("rst_game_over", qif.game_over, 1'b0);
        check("rst_pulses", {qif.correct, qif.wrong}, 2'b00);
        rst = 1'b1;
        tick();
        qif.submit = 1'b1;
        tick();
        qif.submit = 1'b0;
        check("idle_submit_ignored", {qif.correct, qif.wrong, qif.busy}, 3'b000);

        // Start game 1
        qif.start = 1'b1;
        tick();
        qif.start = 1'b0;
        check("start_busy", qif.busy, 1'b1);
        tick();
        $display("game1 round=%0d target=%02h", qif.round_num, qif.target);
        check("r1_target", qif.target, 8'h5A);
        check("r1_round", qif.round_num, 7'd1);
        check("r1_flags", {qif.correct, qif.wrong, qif.game_over}, 3'b000);

        // Round 1: correct guess
        qif.guess  = 8'h5A;
        qif.submit = 1'b1;
        tick();
        qif.submit = 1'b0;
        check("r1_no_early_pulse", {qif.correct, qif.wrong}, 2'b00);
        tick();
        $display("round1 guess=5a correct=%0b wrong=%0b", qif.correct, qif.wrong);
        check("r1_correct", {qif.correct, qif.wrong}, 2'b10);
        tick();
        check("r1_pulse_width", {qif.correct, qif.wrong}, 2'b00);
        check("r2_target", qif.target, 8'hB4);
        check("r2_round", qif.round_num, 7'd2);

        // Round 2: wrong guess
        qif.guess  = 8'h00;
        qif.submit = 1'b1;
        tick();
        qif.submit = 1'b0;
        tick();
        $display("round2 guess=00 correct=%0b wrong=%0b", qif.correct, qif.wrong);
        check("r2_wrong", {qif.correct, qif.wrong}, 2'b01);
        tick();
        check("r2_pulse_width", {qif.correct, qif.wrong}, 2'b00);
        check("r3_round", qif.round_num, 7'd3);
        check("r3_target", qif.target, 8'h69);

        // Round 3: timeout after 16 waiting cycles
        ticks(16);
        check("r3_no_early_timeout", {qif.correct, qif.wrong}, 2'b00);
        tick();
        $display("round3 timeout correct=%0b wrong=%0b", qif.correct, qif.wrong);
        check("r3_timeout_wrong", {qif.correct, qif.wrong}, 2'b01);
        tick();
        check("done_game_over", qif.game_over, 1'b1);
        check("done_busy", qif.busy, 1'b0);
        check("done_round", qif.round_num, 7'd3);
        check("done_target_hold", qif.target, 8'h69);

        // Submits in DONE are ignored
        qif.guess  = 8'h69;
        qif.submit = 1'b1;
        tick();
        qif.submit = 1'b0;
        tick();
        check("done_submit_ignored_a", {qif.correct, qif.wrong}, 2'b00);
        tick();
        check("done_submit_ignored_b", {qif.correct, qif.wrong, qif.game_over}, 3'b001);

        // Game 2 continues the LFSR sequence
        qif.start = 1'b1;
        tick();
        qif.start = 1'b0;
        check("g2_game_over_clr", qif.game_over, 1'b0);
        check("g2_round_clr", qif.round_num, 7'd0);
        tick();
        $display("game2 round=%0d target=%02h", qif.round_num, qif.target);
        check("g2_round", qif.round_num, 7'd1);
        check("g2_target", qif.target, 8'hD2);

        // Submit in the timeout cycle with a correct guess
        ticks(15);
        qif.guess  = 8'hD2;
        qif.submit = 1'b1;
        tick();
        qif.submit = 1'b0;
        tick();
        $display("game2 round1 late guess=d2 correct=%0b wrong=%0b", qif.correct, qif.wrong);
        check("g2_coincident_correct", {qif.correct, qif.wrong}, 2'b10);
        tick();
        check("g2_r2_target", qif.target, 8'hA4);
        check("g2_r2_round", qif.round_num, 7'd2);

        // Mid-WAIT reset with a pending correct submit
        ticks(3);
        qif.guess  = 8'hA4;
        qif.submit = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_async", {qif.target, 1'b0, qif.round_num, qif.busy, qif.game_over, qif.correct, qif.wrong},
              {8'h00, 1'b0, 7'd0, 4'b0000});
        tick();
        qif.submit = 1'b0;
        tick();
        check("mid_rst_no_pulse", {qif.correct, qif.wrong, qif.busy}, 3'b000);
        rst = 1'b1;
        tick();
        check("mid_rst_still_idle", {qif.correct, qif.wrong, qif.busy}, 3'b000);

        // Restart after reset: sequence reseeded
        qif.start = 1'b1;
        tick();
        qif.start = 1'b0;
        tick();
        $display("after reset round=%0d target=%02h", qif.round_num, qif.target);
        check("reseed_target", qif.target, 8'h5A);
        check("reseed_round", qif.round_num, 7'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
